// File: rtl/spi_frame_rx_pkg.sv
`default_nettype none
// ============================================================================
// Module   : spi_frame_pkg
// Purpose  : Shared types and constants for the SPI frame receiver: FSM state
//            encoding, frame length and the bit positions of the rw, address
//            and data fields inside a 16-bit frame.
// Revision : 1.0 - initial release
// ============================================================================
package spi_frame_pkg;

    // Frame layout: [15] rw, [14:8] address, [7:0] data, MSB shifted first.
    localparam int FRAME_BITS = 16;
    localparam int RW_BIT     = 15;
    localparam int ADDR_MSB   = 14;
    localparam int ADDR_LSB   = 8;
    localparam int CNT_W      = 5;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SHIFT   = 2'd1,
        OVERRUN = 2'd2,
        EMIT    = 2'd3
    } state_t;

endpackage : spi_frame_pkg
`default_nettype wire

// File: rtl/spi_frame_rx_if.sv
`default_nettype none
// ============================================================================
// Module   : spi_frame_rx_if
// Purpose  : Bundles the raw SPI pins and the decoded-frame strobe.
//            slave  : receiver side (pins in, frame out)
//            master : driver/consumer side (pins out, frame in)
// Signals  : sclk, copi, ncs (raw, asynchronous), frame_valid, frame_rw,
//            frame_addr[ADDR_W], frame_data[DATA_W], and frame_err when
//            SPI_FRAME_ERR_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
interface spi_frame_rx_if #(
    parameter int ADDR_W = 7,
    parameter int DATA_W = 8
);
    logic              sclk;
    logic              copi;
    logic              ncs;
    logic              frame_valid;
    logic              frame_rw;
    logic [ADDR_W-1:0] frame_addr;
    logic [DATA_W-1:0] frame_data;
`ifdef SPI_FRAME_ERR_EN
    logic              frame_err;

    modport slave  (input  sclk, copi, ncs,
                    output frame_valid, frame_rw, frame_addr, frame_data, frame_err);
    modport master (output sclk, copi, ncs,
                    input  frame_valid, frame_rw, frame_addr, frame_data, frame_err);
`else
    modport slave  (input  sclk, copi, ncs,
                    output frame_valid, frame_rw, frame_addr, frame_data);
    modport master (output sclk, copi, ncs,
                    input  frame_valid, frame_rw, frame_addr, frame_data);
`endif
endinterface : spi_frame_rx_if
`default_nettype wire

// File: rtl/spi_pin_sync.sv
`default_nettype none
// ============================================================================
// Module   : spi_pin_sync
// Purpose  : STAGES-deep synchroniser for one asynchronous pin, followed by a
//            previous-value flop used for edge detection.
// Ports    : clk, rst   - clock, synchronous active-high reset
//            i_pin      - raw asynchronous input
//            o_sync     - synchronised level
//            o_rise     - one-cycle pulse on a synchronised 0->1
//            o_fall     - one-cycle pulse on a synchronised 1->0
// Revision : 1.0 - initial release
// ============================================================================
module spi_pin_sync #(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  wire logic clk,
    input  wire logic rst,
    input  wire logic i_pin,
    output logic      o_sync,
    output logic      o_rise,
    output logic      o_fall
);
    logic [STAGES-1:0] r_stage;
    logic              r_prev;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stage <= {STAGES{RST_VAL}};
            r_prev  <= RST_VAL;
        end else begin
            r_stage <= {r_stage[STAGES-2:0], i_pin};
            r_prev  <= r_stage[STAGES-1];
        end
    end

    assign o_sync = r_stage[STAGES-1];
    assign o_rise = r_stage[STAGES-1] & ~r_prev;
    assign o_fall = ~r_stage[STAGES-1] & r_prev;

endmodule : spi_pin_sync
`default_nettype wire

// File: rtl/spi_frame_rx.sv
`default_nettype none
// ============================================================================
// Module   : spi_frame_rx
// Purpose  : SPI mode-0 frame receiver. Synchronises SCLK/COPI/nCS into clk,
//            shifts 16-bit frames MSB first and strobes {rw, addr, data} for
//            one cycle per well-formed frame. Short (underrun) and long
//            (overrun) frames are discarded.
// Ports    : clk, rst - clock, synchronous active-high reset
//            bus      - spi_frame_rx_if.slave (pins in, frame strobe out)
// Options  : SPI_FRAME_ERR_EN - adds bus.frame_err, a one-cycle pulse per
//            discarded frame, timed like frame_valid.
// Revision : 1.0 - initial release
// ============================================================================
module spi_frame_rx
    import spi_frame_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int ADDR_W      = 7,
    parameter int DATA_W      = 8
) (
    input  wire logic      clk,
    input  wire logic      rst,
    spi_frame_rx_if.slave  bus
);
    // A chip-select fall only opens a frame after nCS has been seen high for
    // the minimum legal high time. This rejects the artificial fall produced
    // when the reset value (1) drains out of the nCS chain while the pin is
    // still low, so a frame interrupted by reset is never resumed.
    localparam logic [2:0] c_NCS_HI_MIN = 3'(SYNC_STAGES + 1);

    logic w_sclk_rise, w_sclk_sync, w_sclk_fall;
    logic w_copi_sync, w_copi_rise, w_copi_fall;
    logic w_ncs_sync,  w_ncs_rise,  w_ncs_fall;
    logic w_unused_edges;

    spi_pin_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (
        .clk(clk), .rst(rst), .i_pin(bus.sclk),
        .o_sync(w_sclk_sync), .o_rise(w_sclk_rise), .o_fall(w_sclk_fall)
    );
    spi_pin_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_copi (
        .clk(clk), .rst(rst), .i_pin(bus.copi),
        .o_sync(w_copi_sync), .o_rise(w_copi_rise), .o_fall(w_copi_fall)
    );
    spi_pin_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_ncs (
        .clk(clk), .rst(rst), .i_pin(bus.ncs),
        .o_sync(w_ncs_sync), .o_rise(w_ncs_rise), .o_fall(w_ncs_fall)
    );

    assign w_unused_edges = w_sclk_sync ^ w_sclk_fall ^ w_copi_rise ^ w_copi_fall;

    state_t                r_state;
    logic [CNT_W-1:0]      r_cnt;
    logic [FRAME_BITS-1:0] r_shift;
    logic [2:0]            r_ncs_hi_cnt;
    logic                  r_valid;
    logic                  r_rw;
    logic [ADDR_W-1:0]     r_addr;
    logic [DATA_W-1:0]     r_data;
`ifdef SPI_FRAME_ERR_EN
    logic                  r_err_pend;
    logic                  r_err;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_cnt        <= '0;
            r_shift      <= '0;
            r_ncs_hi_cnt <= '0;
            r_valid      <= 1'b0;
            r_rw         <= 1'b0;
            r_addr       <= '0;
            r_data       <= '0;
`ifdef SPI_FRAME_ERR_EN
            r_err_pend   <= 1'b0;
            r_err        <= 1'b0;
`endif
        end else begin
            r_valid <= 1'b0;
`ifdef SPI_FRAME_ERR_EN
            // Discard is decided on the ncs_rise cycle; the extra flop lines
            // the error pulse up with where frame_valid would have appeared.
            r_err_pend <= 1'b0;
            r_err      <= r_err_pend;
`endif
            if (!w_ncs_sync) begin
                r_ncs_hi_cnt <= '0;
            end else if (r_ncs_hi_cnt != c_NCS_HI_MIN) begin
                r_ncs_hi_cnt <= r_ncs_hi_cnt + 3'd1;
            end

            case (r_state)
                IDLE: begin
                    // Any SCLK edge coincident with the fall is ignored here.
                    if (w_ncs_fall && (r_ncs_hi_cnt == c_NCS_HI_MIN)) begin
                        r_cnt   <= '0;
                        r_shift <= '0;
                        r_state <= SHIFT;
                    end
                end
                SHIFT: begin
                    // ncs_rise wins over a coincident sclk_rise: that edge is dropped.
                    if (w_ncs_rise) begin
                        if (r_cnt == CNT_W'(FRAME_BITS)) begin
                            r_state <= EMIT;
                        end else begin
                            r_state <= IDLE;
`ifdef SPI_FRAME_ERR_EN
                            r_err_pend <= 1'b1;
`endif
                        end
                    end else if (w_sclk_rise && !w_ncs_sync) begin
                        if (r_cnt == CNT_W'(FRAME_BITS)) begin
                            r_state <= OVERRUN;
                        end else begin
                            r_shift <= {r_shift[FRAME_BITS-2:0], w_copi_sync};
                            r_cnt   <= r_cnt + CNT_W'(1);
                        end
                    end
                end
                OVERRUN: begin
                    if (w_ncs_rise) begin
                        r_state <= IDLE;
`ifdef SPI_FRAME_ERR_EN
                        r_err_pend <= 1'b1;
`endif
                    end
                end
                EMIT: begin
                    r_valid <= 1'b1;
                    r_rw    <= r_shift[RW_BIT];
                    r_addr  <= r_shift[ADDR_MSB:ADDR_LSB];
                    r_data  <= r_shift[DATA_W-1:0];
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.frame_valid = r_valid;
    assign bus.frame_rw    = r_rw;
    assign bus.frame_addr  = r_addr;
    assign bus.frame_data  = r_data;
`ifdef SPI_FRAME_ERR_EN
    assign bus.frame_err   = r_err;
`endif

endmodule : spi_frame_rx
`default_nettype wire
